// File: rtl/trans_done_dispatch.sv
// Latches per-channel transfer-complete pulses and dispatches one fixed-priority
// command per pending channel to the engine, then waits for its completion or a timeout.
//
//  state       | meaning
//  ------------+------------------------------------------------------------
//  S_IDLE      | no command outstanding; picks lowest pending channel
//  S_ISSUE     | cmd_valid held with stable payload until cmd_ready
//  S_WAIT_DONE | command accepted; waiting for cmd_done or timeout
module trans_done_dispatch #(
    parameter logic [31:0] BASE_ADDR   = 32'h4600_0000,
    parameter logic [31:0] CH_STRIDE   = 32'h0001_0000,
    parameter logic [15:0] BURST_LEN   = 16'd256,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  Trans_done_onehot,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_ch,
    output logic [31:0] cmd_addr,
    output logic [15:0] cmd_len,
    input  logic        cmd_done,
    output logic        busy,
    output logic [7:0]  ch_done_mask,
    output logic        all_done,
    output logic        err_timeout,
    output logic        err_overrun,
    input  logic        soft_clear
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_pending;
    logic [23:0] r_cnt;
    logic        r_cmd_valid;
    logic [2:0]  r_cmd_ch;
    logic [31:0] r_cmd_addr;
    logic [15:0] r_cmd_len;
    logic        r_busy;
    logic [7:0]  r_mask;
    logic        r_all_done;
    logic        r_err_tmo;
    logic        r_err_ovr;

    logic [2:0]  w_sel_ch;
    logic        w_issue_go;
    logic        w_hs;
    logic        w_done_ev;
    logic        w_tmo;
    logic [7:0]  w_clr_mask;
    logic [7:0]  w_set_mask;
    logic [31:0] w_sel_addr;

    // Lowest set index has priority: scan downward so the last hit wins.
    always_comb begin
        w_sel_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_pending[i]) w_sel_ch = 3'(i);
        end
    end

    assign w_sel_addr = BASE_ADDR + ({29'd0, w_sel_ch} * CH_STRIDE);

    always_comb begin
        w_state_nxt = r_state;
        w_issue_go  = 1'b0;
        w_hs        = 1'b0;
        w_done_ev   = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pending) begin
                    w_issue_go  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (cmd_done) begin
                    w_done_ev   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == TIMEOUT_CYC - 24'd1) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_clr_mask = w_hs      ? (8'd1 << r_cmd_ch) : 8'd0;
    assign w_set_mask = w_done_ev ? (8'd1 << r_cmd_ch) : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= 8'd0;
            r_cnt       <= 24'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_ch    <= 3'd0;
            r_cmd_addr  <= BASE_ADDR;
            r_cmd_len   <= BURST_LEN;
        end else begin
            // A pulse landing on the handshake edge of its own channel re-arms it.
            r_pending <= (r_pending & ~w_clr_mask) | Trans_done_onehot;
            if (w_issue_go) begin
                r_cmd_valid <= 1'b1;
                r_cmd_ch    <= w_sel_ch;
                r_cmd_addr  <= w_sel_addr;
                r_cmd_len   <= BURST_LEN;
            end else if (w_hs) begin
                r_cmd_valid <= 1'b0;
            end
            if (w_hs) begin
                r_cnt <= 24'd0;
            end else if (r_state == S_WAIT_DONE) begin
                r_cnt <= r_cnt + 24'd1;
            end
        end
    end

    // Sticky status: soft_clear wipes first, so any same-edge set survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask     <= 8'd0;
            r_all_done <= 1'b0;
            r_err_tmo  <= 1'b0;
            r_err_ovr  <= 1'b0;
        end else begin
            r_mask     <= (soft_clear ? 8'd0 : r_mask) | w_set_mask;
            r_all_done <= (r_mask == 8'hFF) && !soft_clear;
            r_err_tmo  <= (r_err_tmo && !soft_clear) || w_tmo;
            r_err_ovr  <= (r_err_ovr && !soft_clear) ||
                          (|(Trans_done_onehot & r_pending & ~w_clr_mask));
        end
    end

    assign cmd_valid    = r_cmd_valid;
    assign cmd_ch       = r_cmd_ch;
    assign cmd_addr     = r_cmd_addr;
    assign cmd_len      = r_cmd_len;
    assign busy         = r_busy;
    assign ch_done_mask = r_mask;
    assign all_done     = r_all_done;
    assign err_timeout  = r_err_tmo;
    assign err_overrun  = r_err_ovr;

endmodule
